zap_sync_fifo_lvl: RTL

Parametrised synchronous show-ahead FIFO with a registered occupancy count, threshold flags and sticky error flags. It supersedes the plain synchronous FIFO wherever a producer needs early back-pressure (almost-full) or a consumer needs burst hints (almost-empty). Typical users are the bus-interface and store buffers in the ZAP memory path. Single clock domain.

---
 rtl/zap_sync_fifo_lvl_if.sv | 35 +++
 rtl/zap_sync_fifo_lvl.sv | 101 ++++++++++
 2 files changed

// File: rtl/zap_sync_fifo_lvl_if.sv
// FIFO handshake bundle for zap_sync_fifo_lvl.
// master drives push/pop/clear; slave is the FIFO side.
interface zap_sync_fifo_lvl_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             i_wr_en;
  logic [WIDTH-1:0] i_data;
  logic             i_ack;
  logic             i_clear;
  logic [WIDTH-1:0] o_data;
  logic             o_empty;
  logic             o_empty_n;
  logic             o_full;
  logic             o_full_n;
  logic             o_afull;
  logic             o_aempty;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_wr_en, i_data, i_ack, i_clear,
    input  o_data, o_empty, o_empty_n, o_full, o_full_n,
    input  o_afull, o_aempty, o_level, o_overflow, o_underflow
  );

  modport slave (
    input  i_wr_en, i_data, i_ack, i_clear,
    output o_data, o_empty, o_empty_n, o_full, o_full_n,
    output o_afull, o_aempty, o_level, o_overflow, o_underflow
  );
endinterface

// File: rtl/zap_sync_fifo_lvl.sv
// Show-ahead sync FIFO with registered level and threshold flags.
// Sticky overflow/underflow built only with ZAP_SYNC_FIFO_ERR_FLAGS_EN.
module zap_sync_fifo_lvl #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 32,
  parameter int AFULL_THRESH  = DEPTH - 1,
  parameter int AEMPTY_THRESH = 1
) (
  input logic             i_clk,
  input logic             i_reset,
  zap_sync_fifo_lvl_if.slave bus
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int AW = LW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]    wptr;
  logic [LW-1:0]    rptr;
  logic [LW-1:0]    level;
  logic [LW-1:0]    wptr_nxt;
  logic [LW-1:0]    rptr_nxt;
  logic [LW-1:0]    level_nxt;
  logic             empty;
  logic             full;
  logic             afull;
  logic             aempty;
  logic             write_ok;
  logic             read_ok;

  // Acceptance uses the registered flags only.
  assign write_ok = bus.i_wr_en & ~full;
  assign read_ok  = bus.i_ack & ~empty;

  // Next pointers; level is their modular difference.
  always_comb begin
    wptr_nxt  = wptr + {{AW{1'b0}}, write_ok};
    rptr_nxt  = rptr + {{AW{1'b0}}, read_ok};
    level_nxt = wptr_nxt - rptr_nxt;
  end

  // Pointer, level and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear) begin
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
      afull  <= 1'b0;
      aempty <= 1'b1;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      level  <= level_nxt;
      empty  <= (level_nxt == '0);
      full   <= (level_nxt == LW'(DEPTH));
      afull  <= (level_nxt >= LW'(AFULL_THRESH));
      aempty <= (level_nxt <= LW'(AEMPTY_THRESH));
    end
  end

  // Storage write; a write racing a clear is orphaned by the pointer reset.
  always_ff @(posedge i_clk) begin
    if (write_ok)
      mem[wptr[AW-1:0]] <= bus.i_data;
  end

  assign bus.o_data    = mem[rptr[AW-1:0]];
  assign bus.o_empty   = empty;
  assign bus.o_empty_n = ~empty;
  assign bus.o_full    = full;
  assign bus.o_full_n  = ~full;
  assign bus.o_afull   = afull;
  assign bus.o_aempty  = aempty;
  assign bus.o_level   = level;

`ifdef ZAP_SYNC_FIFO_ERR_FLAGS_EN
  logic overflow;
  logic underflow;

  // Sticky error capture, cleared by reset or flush.
  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.i_wr_en && full)
        overflow <= 1'b1;
      if (bus.i_ack && empty)
        underflow <= 1'b1;
    end
  end

  assign bus.o_overflow  = overflow;
  assign bus.o_underflow = underflow;
`else
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif

endmodule
